// File: rtl/serial_mem_loader_if.sv
// rtl/serial_mem_loader_if.sv - serial byte link and memory-port bundle for serial_mem_loader
interface serial_mem_loader_if;
    logic [7:0]  rs232in_data;
    logic        rs232in_attention;
    logic        rs232out_busy;
    logic        rs232out_w;
    logic [7:0]  rs232out_d;
    logic        mem_waitrequest;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;

    modport master (
        input  rs232in_data, rs232in_attention, rs232out_busy,
        input  mem_waitrequest, mem_readdata, mem_readdataid,
        output rs232out_w, rs232out_d,
        output mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
    );

    modport slave (
        output rs232in_data, rs232in_attention, rs232out_busy,
        output mem_waitrequest, mem_readdata, mem_readdataid,
        input  rs232out_w, rs232out_d,
        input  mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
    );
endinterface

// File: rtl/serial_mem_loader.sv
// rtl/serial_mem_loader.sv - host byte commands to single-word memory writes/reads with serial replies
module serial_mem_loader #(
    parameter logic [1:0] ID      = 2'd3,
    parameter int         TIMEOUT = 7_500_000,
    parameter int         TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                clock,
    input  logic                rst,
    serial_mem_loader_if.master bus,
    output logic                active,
    output logic                go
);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, WAIT_RD, TX, TX_GAP
    } state_t;

    state_t        state, state_next;
    logic          cmd_write, cmd_write_next;
    logic [1:0]    byte_cnt, byte_cnt_next;
    logic [TW-1:0] tmo_cnt, tmo_cnt_next;
    logic [31:0]   addr, addr_next;
    logic [31:0]   wdata, wdata_next;
    logic [31:0]   tx_buf, tx_buf_next;
    logic [2:0]    tx_left, tx_left_next;
    logic          go_next, tx_w_next, rd_next, wr_next;
    logic [7:0]    tx_d_next;
    logic [29:0]   maddr_next;
    logic [31:0]   mwdata_next;
    logic          timed_out;

    assign bus.mem_id            = ID;
    assign bus.mem_writedatamask = 4'hF;
    assign active                = (state != IDLE);
    // Timeout outranks a byte arriving in the same cycle.
    assign timed_out             = (tmo_cnt == TW'(TIMEOUT));

    always_ff @(posedge clock) begin
        if (rst) begin
            state             <= IDLE;
            cmd_write         <= 1'b0;
            byte_cnt          <= '0;
            tmo_cnt           <= '0;
            addr              <= '0;
            wdata             <= '0;
            tx_buf            <= '0;
            tx_left           <= '0;
            go                <= 1'b0;
            bus.rs232out_w    <= 1'b0;
            bus.rs232out_d    <= '0;
            bus.mem_read      <= 1'b0;
            bus.mem_write     <= 1'b0;
            bus.mem_address   <= '0;
            bus.mem_writedata <= '0;
        end else begin
            state             <= state_next;
            cmd_write         <= cmd_write_next;
            byte_cnt          <= byte_cnt_next;
            tmo_cnt           <= tmo_cnt_next;
            addr              <= addr_next;
            wdata             <= wdata_next;
            tx_buf            <= tx_buf_next;
            tx_left           <= tx_left_next;
            go                <= go_next;
            bus.rs232out_w    <= tx_w_next;
            bus.rs232out_d    <= tx_d_next;
            bus.mem_read      <= rd_next;
            bus.mem_write     <= wr_next;
            bus.mem_address   <= maddr_next;
            bus.mem_writedata <= mwdata_next;
        end
    end

    always_comb begin
        state_next     = state;
        cmd_write_next = cmd_write;
        byte_cnt_next  = byte_cnt;
        tmo_cnt_next   = tmo_cnt;
        addr_next      = addr;
        wdata_next     = wdata;
        tx_buf_next    = tx_buf;
        tx_left_next   = tx_left;
        go_next        = 1'b0;
        tx_w_next      = 1'b0;
        tx_d_next      = bus.rs232out_d;
        rd_next        = bus.mem_read;
        wr_next        = bus.mem_write;
        maddr_next     = bus.mem_address;
        mwdata_next    = bus.mem_writedata;

        case (state)
            IDLE: begin
                byte_cnt_next = '0;
                tmo_cnt_next  = '0;
                if (bus.rs232in_attention) begin
                    case (bus.rs232in_data)
                        8'h57: begin cmd_write_next = 1'b1; state_next = GET_ADDR; end
                        8'h52: begin cmd_write_next = 1'b0; state_next = GET_ADDR; end
                        8'h47: begin
                            go_next      = 1'b1;
                            tx_buf_next  = {8'h2E, 24'h0};
                            tx_left_next = 3'd1;
                            state_next   = TX;
                        end
                        default: begin
                            tx_buf_next  = {8'h3F, 24'h0};
                            tx_left_next = 3'd1;
                            state_next   = TX;
                        end
                    endcase
                end
            end
            GET_ADDR: begin
                if (timed_out) begin
                    state_next = IDLE;
                end else if (bus.rs232in_attention) begin
                    addr_next     = {addr[23:0], bus.rs232in_data};
                    tmo_cnt_next  = '0;
                    byte_cnt_next = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (cmd_write) begin
                            state_next = GET_DATA;
                        end else begin
                            rd_next    = 1'b1;
                            maddr_next = addr_next[31:2];
                            state_next = MEM_RD;
                        end
                    end
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                end
            end
            GET_DATA: begin
                if (timed_out) begin
                    state_next = IDLE;
                end else if (bus.rs232in_attention) begin
                    wdata_next    = {wdata[23:0], bus.rs232in_data};
                    tmo_cnt_next  = '0;
                    byte_cnt_next = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        wr_next     = 1'b1;
                        maddr_next  = addr[31:2];
                        mwdata_next = wdata_next;
                        state_next  = MEM_WR;
                    end
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                end
            end
            MEM_WR: begin
                if (!bus.mem_waitrequest) begin
                    wr_next      = 1'b0;
                    tx_buf_next  = {8'h2E, 24'h0};
                    tx_left_next = 3'd1;
                    state_next   = TX;
                end
            end
            MEM_RD: begin
                if (!bus.mem_waitrequest) begin
                    rd_next    = 1'b0;
                    state_next = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bus.mem_readdataid == ID) begin
                    tx_buf_next  = bus.mem_readdata;
                    tx_left_next = 3'd4;
                    state_next   = TX;
                end
            end
            TX: begin
                if (!bus.rs232out_busy) begin
                    tx_w_next    = 1'b1;
                    tx_d_next    = tx_buf[31:24];
                    tx_buf_next  = {tx_buf[23:0], 8'h00};
                    tx_left_next = tx_left - 3'd1;
                    state_next   = TX_GAP;
                end
            end
            TX_GAP: begin
                // Busy lags the strobe by a cycle, so it is not looked at here.
                state_next = (tx_left != 3'd0) ? TX : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/serial_mem_loader.md
Name: serial_mem_loader

Overview:
- Serial-driven bus initiator on the mem_* interface: turns host byte commands arriving from rs232in into single-word SRAM writes and reads, and returns acknowledges and read data through rs232out.
- Sits beside yari on the memory arbiter port, sharing the sram_ctrl responder.
- Used to download images and peek/poke memory without the CPU.

Parameters:
- ID, 2'd3: mem_id tag driven on requests; read data is accepted only when mem_readdataid == ID; must be nonzero.
- TIMEOUT, 7_500_000: idle cycles tolerated between bytes of one command before it is aborted.
- TW, $clog2(TIMEOUT+1): timeout counter width.

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous active-high reset
- rs232in_data  in  8  received byte, valid when attention=1
- rs232in_attention  in  1  one-cycle pulse per received byte
- rs232out_busy  in  1  transmitter busy
- rs232out_w  out  1  one-cycle transmit strobe
- rs232out_d  out  8  byte to transmit, valid with rs232out_w
- mem_waitrequest  in  1  responder stall
- mem_id  out  2  request tag, constant ID
- mem_address  out  30  word address
- mem_read  out  1  read request
- mem_write  out  1  write request
- mem_writedata  out  32  write data
- mem_writedatamask  out  4  byte enables; always 4'hF on writes
- mem_readdata  in  32  read data
- mem_readdataid  in  2  tag of mem_readdata; 0 = none
- active  out  1  high whenever state != IDLE
- go  out  1  one-cycle pulse on a 'G' command

Behaviour:
- Reset, synchronous and dominant:
  - state=IDLE.
  - rs232out_w, mem_read, mem_write, go, active = 0.
  - rs232out_d, mem_address, mem_writedata = 0.
  - Byte/timeout counters = 0.
  - Any in-flight request is dropped the same cycle; a later read return is ignored.
- Command bytes, all multi-byte fields big-endian:
  - 'W' 0x57: A3 A2 A1 A0, then D3 D2 D1 D0 -> write, reply '.' 0x2E.
  - 'R' 0x52: A3..A0 -> read, reply D3 D2 D1 D0.
  - 'G' 0x47: go pulses in the cycle after the command byte, reply '.'.
  - Any other byte: reply '?' 0x3F.
- mem_address = addr[31:2]; addr[1:0] are ignored.
- States:
  - IDLE: on attention, decode the byte.
  - GET_ADDR: 4 bytes shifted in, counter 0..3. Then -> GET_DATA ('W') or MEM_RD ('R').
  - GET_DATA: 4 bytes shifted in, then -> MEM_WR.
  - MEM_WR / MEM_RD: the request strobe is asserted on state entry. Address, data and strobe are held stable while mem_waitrequest=1. In the first cycle with mem_waitrequest=0 the request is accepted and the strobe deasserts the next cycle. MEM_WR -> TX with '.'; MEM_RD -> WAIT_RD.
  - WAIT_RD: capture mem_readdata in the cycle mem_readdataid==ID, then -> TX with 4 bytes.
  - TX: when rs232out_busy=0, pulse rs232out_w for 1 cycle with the next byte (MSB first), then -> TX_GAP.
  - TX_GAP: wait exactly 1 cycle without sampling busy. Then -> TX if bytes remain, else -> IDLE.
- Timeout:
  - In GET_ADDR/GET_DATA, the counter increments each cycle without attention and clears on attention.
  - Reaching TIMEOUT -> IDLE silently, with no reply.
  - No timeout applies in MEM_*, WAIT_RD or TX.
- Bytes with attention arriving in MEM_WR, MEM_RD, WAIT_RD, TX or TX_GAP are discarded; the host must wait for the reply before sending.
- Attention in the same cycle a timeout fires: the timeout wins and the byte is dropped.
- Read-data returns tagged with IDs other than ID are ignored in every state.
- Request latency:
  - mem_write asserts 1 cycle after the final data byte's attention.
  - mem_read asserts 1 cycle after A0's attention.
- go is 0 at all other times.

Test Plan:
- Write accept: send 57 40 00 00 10 DE AD BE EF with waitrequest=0.
  - mem_write is high exactly 1 cycle with address 30'h1000_0004, data 32'hDEADBEEF, mask F.
  - Reply 2E.
- Held request: repeat the write with waitrequest held high 5 cycles.
  - Write and its outputs are stable for 6 cycles, then deasserted.
  - Exactly one 2E is sent.
- Read with tag filtering: send 52 40 00 00 13 (byte offset ignored; address 30'h1000_0004).
  - Responder returns id=1 data 11111111 first, then id=3 data CAFEF00D.
  - Reply is CA FE F0 0D.
  - Each rs232out_w is separated by ≥1 gap cycle and issued only while busy=0.
- Unknown and go commands:
  - Byte 0x00 -> reply 3F.
  - Byte 0x47 -> go high 1 cycle, reply 2E.
  - active is low afterwards.
- Timeout: send 57 40 then stall TIMEOUT cycles (set TIMEOUT=100).
  - Returns to IDLE, no mem_write, no reply.
  - A following 47 is decoded as a fresh command.
- Reset mid-operation: assert rst while mem_read is held by waitrequest.
  - All outputs are 0 the next cycle.
  - A subsequent id=3 return causes no transmit.
